// File: rtl/shared_adder_pkg.sv
// Shared arithmetic helpers and default sizing for the shared signed adder.
package shared_adder_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 4;
    localparam int DEF_CNT_W = 8;

    // Signed overflow from sign bits only, so it works for any operand width.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/shared_signed_adder_arbiter_rr.sv
// Combinational round-robin grant: first valid request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx[IW-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[IW-1:0];
            end
        end
        if (enable && found)
            grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/shared_signed_adder_arbiter.sv
// One registered signed adder shared by N_REQ requesters through a round-robin arbiter.
module shared_signed_adder_arbiter
    import shared_adder_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [W-1:0]             res_sum,
    output logic                     res_overflow,
    output logic [CNT_W-1:0]         ovf_count
);

    localparam int ID_W = $clog2(N_REQ);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [W-1:0]    sum;
        logic            overflow;
    } result_t;

    result_t         res_q;
    logic            valid_q;
    logic [ID_W-1:0] ptr;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0] gidx;
    logic            stage_free;
    logic            xfer;
    logic [W-1:0]    a_g, b_g, sum_g;
    logic            ovf_g;

    assign stage_free = !valid_q || res_ready;

    // Gating with !rst keeps req_ready low while the block is held in reset.
    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .enable    (stage_free && !rst),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req_ready = grant & req_valid;
    assign xfer      = |req_ready;

    assign a_g   = req_a[gidx*W +: W];
    assign b_g   = req_b[gidx*W +: W];
    assign sum_g = a_g + b_g;
    assign ovf_g = signed_ovf(a_g[W-1], b_g[W-1], sum_g[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            res_q     <= '0;
            ptr       <= '0;
            ovf_count <= '0;
        end else if (xfer) begin
            valid_q      <= 1'b1;
            res_q.id       <= gidx;
            res_q.sum      <= sum_g;
            res_q.overflow <= ovf_g;
            ptr <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
            if (ovf_g && ovf_count != '1)
                ovf_count <= ovf_count + 1'b1;
        end else if (valid_q && res_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign res_valid    = valid_q;
    assign res_id       = res_q.id;
    assign res_sum      = res_q.sum;
    assign res_overflow = res_q.overflow;

endmodule

// File: tb/tb_shared_signed_adder_arbiter.sv
// Directed bench for the shared signed adder arbiter, plus a CNT_W=2 instance for saturation.
module tb_shared_signed_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_id;
    logic [3:0]  res_sum;
    logic        res_overflow;
    logic [7:0]  ovf_count;

    logic [3:0]  v2 = '0;
    logic [3:0]  rdy2;
    logic [15:0] a2 = '0;
    logic [15:0] b2 = '0;
    logic        rv2;
    logic        rr2 = 1'b0;
    logic [1:0]  id2;
    logic [3:0]  sum2;
    logic        ovf2;
    logic [1:0]  cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shared_signed_adder_arbiter #(.N_REQ(4), .W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_sum(res_sum), .res_overflow(res_overflow), .ovf_count(ovf_count)
    );

    shared_signed_adder_arbiter #(.N_REQ(4), .W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .res_valid(rv2), .res_ready(rr2),
        .res_id(id2), .res_sum(sum2), .res_overflow(ovf2), .ovf_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    task automatic chk_res(input string tag, input logic [1:0] id, input logic [3:0] sum,
                           input logic ovf, input logic [7:0] cnt);
        chk({tag, ".valid"}, 32'(res_valid), 32'd1);
        chk({tag, ".id"}, 32'(res_id), 32'(id));
        chk({tag, ".sum"}, 32'(res_sum), 32'(sum));
        chk({tag, ".ovf"}, 32'(res_overflow), 32'(ovf));
        chk({tag, ".cnt"}, 32'(ovf_count), 32'(cnt));
    endtask

    // Single transfer through requester i with res_ready=1; checks grant and result.
    task automatic one_add(input string tag, input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] sum, input logic ovf, input logic [7:0] cnt);
        set_op(i, a, b);
        req_valid = 4'(1 << i);
        res_ready = 1'b1;
        #1;
        chk({tag, ".rdy"}, 32'(req_ready), 32'(1 << i));
        tick();
        chk_res(tag, 2'(i), sum, ovf, cnt);
    endtask

    initial begin
        // Reset state, with requests pending to show req_ready is held low.
        #2 rst = 1'b1;
        req_valid = 4'hF;
        tick();
        chk("rst.valid", 32'(res_valid), 32'd0);
        chk("rst.id", 32'(res_id), 32'd0);
        chk("rst.sum", 32'(res_sum), 32'd0);
        chk("rst.ovf", 32'(res_overflow), 32'd0);
        chk("rst.cnt", 32'(ovf_count), 32'd0);
        chk("rst.rdy", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single requester 2: ptr ends at 3 after each grant.
        one_add("t1a", 2, 4'd4, 4'd7, 4'b1011, 1'b1, 8'd1);
        one_add("t1b", 2, 4'hC, 4'h9, 4'b0101, 1'b1, 8'd2);
        one_add("t1c", 2, 4'd3, 4'hB, 4'b1110, 1'b0, 8'd2);
        req_valid = '0;
        tick();
        chk("t1.drain", 32'(res_valid), 32'd0);
        chk("t1.hold", 32'(res_sum), 32'hE);

        // Boundary arithmetic through requester 3 (ptr 3 -> 0 each time).
        one_add("t4a", 3, 4'h7, 4'h8, 4'hF, 1'b0, 8'd2);
        one_add("t4b", 3, 4'h8, 4'h8, 4'h0, 1'b1, 8'd3);
        one_add("t4c", 3, 4'h7, 4'h7, 4'hE, 1'b1, 8'd4);
        one_add("t4d", 3, 4'hF, 4'h1, 4'h0, 1'b0, 8'd4);
        one_add("t4e", 3, 4'h4, 4'h4, 4'h8, 1'b1, 8'd5);
        one_add("t4f", 3, 4'hC, 4'hC, 4'h8, 1'b0, 8'd5);

        // Fairness: all valid from ptr 0, operands a=i, b=1.
        for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'd1);
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t2.rdy", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            chk_res("t2", 2'(k % 4), 4'((k % 4) + 1), 1'b0, 8'd5);
        end
        // ptr now 2: only 1 and 3 valid -> 3,1,3,1.
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2b.rdy", 32'(req_ready), (k % 2 == 0) ? 32'b1000 : 32'b0010);
            tick();
            chk("t2b.id", 32'(res_id), (k % 2 == 0) ? 32'd3 : 32'd1);
        end

        // Backpressure: ptr 2, capture id 2 then stall.
        req_valid = 4'hF;
        tick();
        chk_res("t3.cap", 2'd2, 4'd3, 1'b0, 8'd5);
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3.rdy", 32'(req_ready), 32'd0);
            tick();
            chk_res("t3.stall", 2'd2, 4'd3, 1'b0, 8'd5);
        end
        res_ready = 1'b1;
        #1;
        chk("t3.rel.rdy", 32'(req_ready), 32'b1000);
        tick();
        chk_res("t3.next", 2'd3, 4'd4, 1'b0, 8'd5);
        res_ready = 1'b0;
        req_valid = '0;
        tick();
        chk_res("t3.nodup", 2'd3, 4'd4, 1'b0, 8'd5);
        res_ready = 1'b1;
        tick();
        chk("t3.empty", 32'(res_valid), 32'd0);

        // Reset mid-operation: ptr 0, grant 2 with overflow -> ptr 3, result pending.
        one_add("t5.pre", 2, 4'h7, 4'h1, 4'h8, 1'b1, 8'd6);
        res_ready = 1'b0;
        req_valid = '0;
        #3 rst = 1'b1;
        #1;
        chk("t5.valid", 32'(res_valid), 32'd0);
        chk("t5.id", 32'(res_id), 32'd0);
        chk("t5.sum", 32'(res_sum), 32'd0);
        chk("t5.ovf", 32'(res_overflow), 32'd0);
        chk("t5.cnt", 32'(ovf_count), 32'd0);
        #1 rst = 1'b0;
        set_op(1, 4'd2, 4'd3);
        req_valid = 4'b1010;
        res_ready = 1'b1;
        #1;
        chk("t5.rdy", 32'(req_ready), 32'b0010);
        tick();
        chk_res("t5.first", 2'd1, 4'd5, 1'b0, 8'd0);
        req_valid = '0;

        // Saturation on the CNT_W=2 instance.
        a2[3:0] = 4'd7;
        b2[3:0] = 4'd1;
        v2 = 4'b0001;
        rr2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6.sum", 32'(sum2), 32'h8);
            chk("t6.ovf", 32'(ovf2), 32'd1);
            chk("t6.cnt", 32'(cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        v2 = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
